// File: rtl/if_stage.sv
// Instruction fetch stage: sequential PC generation, req/gnt/rvalid fetch
// interface, small instruction buffer feeding decode, redirect handling.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_illegal_o
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, outst_nxt;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]   mem_instr_q [FIFO_DEPTH];
  logic [31:0]   mem_pc_q    [FIFO_DEPTH];
  logic          gnt, push, pop;
  logic [31:0]   head_instr;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  // Legal major opcodes understood by decode.
  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Credits count buffered plus in-flight words, so a response always has room.
  assign imem_req_o  = !rst && !redirect_i &&
                       (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C);
  assign imem_addr_o = fetch_pc_q;

  assign id_valid_o   = (count_q != '0);
  assign head_instr   = mem_instr_q[rptr_q];
  assign id_instr_o   = id_valid_o ? head_instr : 32'h0;
  assign id_pc_o      = id_valid_o ? mem_pc_q[rptr_q] : 32'h0;
  assign id_illegal_o = id_valid_o &&
                        ((head_instr[1:0] != 2'b11) || !opcode_legal(head_instr[6:0]));

  // Next-state for PCs, outstanding/discard counters and buffer pointers.
  always_comb begin
    gnt        = imem_req_o && imem_gnt_i;
    pop        = id_valid_o && id_ready_i;
    push       = 1'b0;
    outst_nxt  = outst_q + CW'(gnt) - CW'(imem_rvalid_i);
    outst_d    = outst_nxt;
    fetch_pc_d = gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      // Everything still in flight (minus a response landing now) is stale.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
      discard_d  = outst_nxt;
    end else if (imem_rvalid_i) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
      end
    end
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    if (redirect_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // Control state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Buffer storage; contents only matter while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wptr_q] <= imem_rdata_i;
      mem_pc_q[wptr_q]    <= resp_pc_q;
    end
  end

  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-configurable in-order memory.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_illegal_o;

  always #5 clk = ~clk;

  if_stage #(.BOOT_ADDR(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_illegal_o(id_illegal_o)
  );

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int cyc    = 0;
  int n_gnt  = 0;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t q[$];
  logic [31:0] ovr [logic [31:0]];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {a[24:0], 7'h13};
  endfunction

  // Memory model: responses driven at negedge, grants sampled 1ns later.
  always @(negedge clk) begin
    cyc++;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memword(q[0].addr);
      q.delete(0);
    end
    #1;
    if (rst) begin
      q.delete();
      n_gnt = 0;
    end else if (imem_req_o && imem_gnt_i) begin
      q.push_back('{imem_addr_o, cyc + lat});
      n_gnt++;
    end
  end

  task automatic cyc_in(input logic rdy, input logic g, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst = 1'b0; id_ready_i = rdy; imem_gnt_i = g; redirect_i = redir; redirect_pc_i = rpc;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; id_ready_i = 1'b0; imem_gnt_i = 1'b0; redirect_i = 1'b0; lat = 1;
    ovr.delete();
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) cyc_in(1'b1, 1'b1, 1'b0, 32'h0);
    do_reset();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
    checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
    checks++; if (id_instr_o !== 32'h0 || id_pc_o !== 32'h0) begin errors++; $display("FAIL rst_id: instr %h pc %h want 0", id_instr_o, id_pc_o); end
    checks++; if (id_illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", id_illegal_o); end
  endtask

  task automatic test_seq_fetch();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc_in(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4*k)) begin errors++; $display("FAIL seq_req c%0d: req %b addr %h want 1 %h", k, imem_req_o, imem_addr_o, 32'(4*k)); end
      if (k >= 2) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4*(k-2)) || id_instr_o !== memword(32'(4*(k-2))) || id_illegal_o !== 1'b0)
          begin errors++; $display("FAIL seq_id c%0d: v %b pc %h instr %h ill %b want pc %h", k, id_valid_o, id_pc_o, id_instr_o, id_illegal_o, 32'(4*(k-2))); end
      end else begin
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL seq_early c%0d: valid %b want 0", k, id_valid_o); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc_in(1'b0, 1'b1, 1'b0, 32'h0);
      if (k >= 2) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_instr_o !== 32'h13) begin errors++; $display("FAIL bp_head c%0d: v %b pc %h instr %h want 1 0 13", k, id_valid_o, id_pc_o, id_instr_o); end
      end
    end
    checks++; if (n_gnt !== 4) begin errors++; $display("FAIL bp_credits: grants %0d want 4", n_gnt); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req: got %b want 0", imem_req_o); end
    for (int k = 10; k < 18; k++) begin
      cyc_in(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4*(k-10)) || id_instr_o !== memword(32'(4*(k-10))))
        begin errors++; $display("FAIL bp_drain c%0d: v %b pc %h instr %h want pc %h", k, id_valid_o, id_pc_o, id_instr_o, 32'(4*(k-10))); end
    end
  endtask

  task automatic test_gnt_hold();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc_in(1'b1, !(k >= 2 && k <= 4), 1'b0, 32'h0);
      if (k >= 2 && k <= 5) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL hold c%0d: req %b addr %h want 1 8", k, imem_req_o, imem_addr_o); end
      end else if (k == 6) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin errors++; $display("FAIL hold_next: req %b addr %h want 1 c", imem_req_o, imem_addr_o); end
      end
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat = 3;
    for (int k = 0; k < 9; k++) begin
      cyc_in(1'b1, 1'b1, k == 2, 32'h0000_1002);
      if (k == 2) begin
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rd_req: got %b want 0", imem_req_o); end
      end
      if (k == 3) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000) begin errors++; $display("FAIL rd_addr: req %b addr %h want 1 1000", imem_req_o, imem_addr_o); end
      end
      if (k >= 3 && k <= 6) begin
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL rd_stale c%0d: valid %b pc %h want 0", k, id_valid_o, id_pc_o); end
      end
      if (k == 7) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h1000 || id_instr_o !== 32'h0008_0013) begin errors++; $display("FAIL rd_first: v %b pc %h instr %h want 1 1000 00080013", id_valid_o, id_pc_o, id_instr_o); end
      end
      if (k == 8) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h1004 || id_instr_o !== 32'h0008_0213) begin errors++; $display("FAIL rd_second: v %b pc %h instr %h want 1 1004 00080213", id_valid_o, id_pc_o, id_instr_o); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2;
    for (int k = 0; k < 9; k++) begin
      cyc_in(1'b1, 1'b1, k == 2 || k == 3, (k == 2) ? 32'h100 : 32'h200);
      if (k == 2 || k == 3) begin
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL b2b_req c%0d: got %b want 0", k, imem_req_o); end
      end
      if (k == 4) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL b2b_addr: req %b addr %h want 1 200", imem_req_o, imem_addr_o); end
      end
      if (k >= 2 && k <= 6) begin
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_stale c%0d: valid %b pc %h want 0", k, id_valid_o, id_pc_o); end
      end
      if (k == 7) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200 || id_instr_o !== 32'h0001_0013) begin errors++; $display("FAIL b2b_first: v %b pc %h instr %h want 1 200 00010013", id_valid_o, id_pc_o, id_instr_o); end
      end
      if (k == 8) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h204 || id_instr_o !== 32'h0001_0213) begin errors++; $display("FAIL b2b_second: v %b pc %h instr %h want 1 204 00010213", id_valid_o, id_pc_o, id_instr_o); end
      end
    end
  endtask

  task automatic test_illegal();
    logic exp_ill [4];
    exp_ill = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    ovr[32'h0] = 32'h0000_000B;
    ovr[32'h4] = 32'h0000_0001;
    ovr[32'h8] = 32'h0000_0073;
    ovr[32'hC] = 32'h0000_006F;
    for (int k = 0; k < 6; k++) begin
      cyc_in(1'b1, 1'b1, 1'b0, 32'h0);
      if (k >= 2) begin
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4*(k-2)) || id_illegal_o !== exp_ill[k-2])
          begin errors++; $display("FAIL illegal c%0d: v %b pc %h instr %h ill %b want ill %b", k, id_valid_o, id_pc_o, id_instr_o, id_illegal_o, exp_ill[k-2]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_gnt_hold();
    test_redirect_stale();
    test_back_to_back();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the core. It sits directly upstream of decode, which consumes opcodes per core_pkg::opcode_e.
- Generates sequential PCs and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0).
FIFO_DEPTH, 4, instruction buffer entries and maximum credits (buffered + outstanding); power of 2, ≥2.

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch word address, bits [1:0] always 0
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid; in-order, ≥1 cycle after gnt
imem_rdata_i  input  32  instruction word
redirect_i  input  1  flush and restart fetch (branch/jump/exception)
redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored (forced 0)
id_valid_o  output  1  instruction available to decode
id_ready_i  input  1  decode accepts the instruction this cycle
id_instr_o  output  32  instruction word
id_pc_o  output  32  PC of id_instr_o
id_illegal_o  output  1  instr[1:0]!=2'b11, or instr[6:0] not a core_pkg::opcode_e member

Behaviour:
- Reset:
  - imem_req_o=0, imem_addr_o=BOOT_ADDR, id_valid_o=0, id_instr_o=0, id_pc_o=0, id_illegal_o=0.
  - Fetch PC and response PC = BOOT_ADDR; FIFO empty; outstanding=0; discard=0.
  - Reset mid-transaction drops everything. The memory side is reset together with this block.
- Credits:
  - imem_req_o=1 when !redirect_i && (fifo_count + outstanding) < FIFO_DEPTH.
  - A pop in the same cycle does not free a credit until the next cycle.
- Request hold: while imem_req_o && !imem_gnt_i, imem_addr_o is stable and req stays high, unless redirect_i arrives.
- Grant: on imem_req_o && imem_gnt_i, fetch PC += 4 (32-bit wrap, 0xFFFF_FFFC → 0) and outstanding++.
- Response:
  - On imem_rvalid_i, outstanding--.
  - If discard>0: discard--, data dropped.
  - Else: push {rdata, resp_pc} into the FIFO, then resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. An rvalid arriving with outstanding==0 is a protocol error; flag it with an assertion.
- Output:
  - id_valid_o = FIFO non-empty; id_instr_o/id_pc_o/id_illegal_o come from the head entry.
  - Head is registered, no rdata→id bypass. Minimum rvalid→id_valid latency is 1 cycle.
  - Pop on id_valid_o && id_ready_i. Head data is stable while valid && !ready.
  - Simultaneous push and pop is allowed at any occupancy, including full.
- Illegal decode is combinational on the head entry. Legal opcodes: 03,0F,13,17,23,33,37,63,67,6F,73 (hex).
- Redirect (highest priority):
  - In the redirect_i cycle:
    - imem_req_o=0.
    - FIFO flushed next edge, so id_valid_o=0 next cycle. A pop in the redirect cycle is still honoured.
    - fetch PC ← {redirect_pc_i[31:2],2'b00}; resp_pc ← same.
    - discard ← outstanding_next, i.e. all requests granted so far and not yet returned, excluding any response arriving this cycle (which is itself dropped).
  - Requests resume the next cycle.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Throughput: with a 1-cycle memory and FIFO_DEPTH=4, sustains 1 instr/cycle when id_ready_i=1.
- Redirect→id_valid latency with a 1-cycle memory: redirect at T, req+gnt at T+1, rvalid at T+2, id_valid at T+3.

Test Plan:
1. Reset release, 1-cycle memory, ready=1 → requests to 0x0,0x4,0x8…; id_pc_o 0x0,0x4,0x8 on consecutive cycles from cycle 3; id_illegal_o=0 for word 0x00000013.
2. id_ready_i=0 for 10 cycles → exactly FIFO_DEPTH credits in use; imem_req_o drops; head stays {0x0, instr0}; after ready rises, no instruction lost or duplicated.
3. gnt withheld 3 cycles → imem_addr_o held at 0x8 with req=1; on gnt, next address 0xC.
4. 3-cycle memory, redirect_i to 0x1002 with 2 outstanding → both stale responses dropped; next id_pc_o=0x1000 with that memory's data; no stale PC ever reaches id.
5. Redirect in the same cycle as gnt and rvalid, then a second redirect to 0x200 on the next cycle → only 0x200 stream delivered to decode.
6. Head word 0x0000000B (opcode 0x0B) or 0x00000001 (bits[1:0]=01) → id_illegal_o=1. Word 0x00000073 → id_illegal_o=0.
